// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op encodings, FSM states,
// word width and small op-classification helpers.
package lsu_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        LSU_LB  = 3'd0,
        LSU_LH  = 3'd1,
        LSU_LW  = 3'd2,
        LSU_LBU = 3'd3,
        LSU_LHU = 3'd4,
        LSU_SB  = 3'd5,
        LSU_SH  = 3'd6,
        LSU_SW  = 3'd7
    } lsu_op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } lsu_state_e;

    function automatic logic op_is_store(lsu_op_e op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

    function automatic logic op_is_word(lsu_op_e op);
        return (op == LSU_LW) || (op == LSU_SW);
    endfunction

    function automatic logic op_is_half(lsu_op_e op);
        return (op == LSU_LH) || (op == LSU_LHU) || (op == LSU_SH);
    endfunction

    // Force the low address bits to the natural alignment of the access size.
    function automatic logic [1:0] align_lo(lsu_op_e op, logic [1:0] lo);
        logic [1:0] res;
        res = lo;
        if (op_is_word(op)) begin
            res = 2'b00;
        end else if (op_is_half(op)) begin
            res = {lo[1], 1'b0};
        end
        return res;
    endfunction

    function automatic logic op_misaligned(lsu_op_e op, logic [1:0] lo);
        logic res;
        res = 1'b0;
        if (op_is_word(op)) begin
            res = (lo != 2'b00);
        end else if (op_is_half(op)) begin
            res = lo[0];
        end
        return res;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: extracts and extends the load lane from a
// memory word, and merges sub-word store data into a memory word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [1:0]        addr_lo,
    input  logic [WORD_W-1:0] word,
    input  logic [WORD_W-1:0] store_data,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] store_word
);

    lsu_op_e    op_e;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [4:0]  byte_lsb;

    assign op_e     = lsu_op_e'(op);
    assign byte_lsb = {addr_lo, 3'b000};

    // Load lane select with sign or zero extension.
    always_comb begin
        byte_sel  = word[byte_lsb +: 8];
        half_sel  = addr_lo[1] ? word[31:16] : word[15:0];
        load_data = word;
        case (op_e)
            LSU_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            LSU_LBU: load_data = {24'h000000, byte_sel};
            LSU_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            LSU_LHU: load_data = {16'h0000, half_sel};
            default: load_data = word;
        endcase
    end

    // Store merge: only the addressed lane is replaced, other bytes pass through.
    always_comb begin
        store_word = store_data;
        case (op_e)
            LSU_SB: begin
                store_word = word;
                store_word[byte_lsb +: 8] = store_data[7:0];
            end
            LSU_SH: begin
                store_word = word;
                if (addr_lo[1]) begin
                    store_word[31:16] = store_data[15:0];
                end else begin
                    store_word[15:0] = store_data[15:0];
                end
            end
            default: store_word = store_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: byte/half/word loads and stores against a
// word-addressed synchronous memory, with read-modify-write for sub-word
// stores. Optional macro LSU_MISALIGN_ERR_EN reports misaligned accesses
// as errors instead of silently aligning them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [TAG_W-1:0]  req_rd,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [31:0]       mem_rdata,
    output logic              resp_valid,
    output logic              resp_wen,
    output logic [TAG_W-1:0]  resp_rd,
    output logic [31:0]       resp_data,
    output logic              resp_err
);

    lsu_state_e          state_q, state_d;
    lsu_op_e             op_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic [WORD_W-1:0]   resp_data_q;
    logic [TAG_W-1:0]    rd_q;

    lsu_op_e             op_in;
    logic                mis_in;
    logic                err_now;
    logic                store_op;
    logic                active;
    logic [WORD_W-1:0]   load_data;
    logic [WORD_W-1:0]   store_word;
    logic                unused_addr_hi;

    assign op_in          = lsu_op_e'(req_op);
    assign store_op       = op_is_store(op_q);
    assign unused_addr_hi = ^req_addr[WORD_W-1:ADDR_W+2];

`ifdef LSU_MISALIGN_ERR_EN
    logic err_q;
    assign mis_in  = op_misaligned(op_in, req_addr[1:0]);
    assign err_now = err_q;

    // Error flag for the request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE && req_valid) begin
            err_q <= mis_in;
        end
    end
`else
    assign mis_in  = 1'b0;
    assign err_now = 1'b0;
`endif

    lsu_lane_align u_lane_align (
        .op         (op_q),
        .addr_lo    (addr_q[1:0]),
        .word       (mem_rdata),
        .store_data (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // State register; reset aborts any access in flight immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: sub-word stores read first, word stores write directly.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (mis_in) begin
                        state_d = RESP;
                    end else if (op_in == LSU_SW) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:      state_d = CAP;
            CAP:     state_d = store_op ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, RMW word capture and load-result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= LSU_LB;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            resp_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q    <= op_in;
                        addr_q  <= {req_addr[ADDR_W+1:2], align_lo(op_in, req_addr[1:0])};
                        wdata_q <= req_wdata;
                        rd_q    <= req_rd;
                        if (mis_in) begin
                            resp_data_q <= '0;
                        end
                    end
                end
                CAP: begin
                    if (store_op) begin
                        wdata_q <= store_word;
                    end else begin
                        resp_data_q <= load_data;
                    end
                end
                WR:      resp_data_q <= '0;
                default: ;
            endcase
        end
    end

    // Memory strobes and response outputs decoded from the current state.
    always_comb begin
        active     = (state_q != IDLE);
        req_ready  = (state_q == IDLE);
        mem_read   = (state_q == RD);
        mem_write  = (state_q == WR);
        mem_addr   = active ? {{(WORD_W-ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]} : '0;
        mem_wdata  = active ? wdata_q : '0;
        resp_valid = (state_q == RESP);
        resp_wen   = (state_q == RESP) && !store_op && !err_now;
        resp_err   = (state_q == RESP) && err_now;
        resp_rd    = rd_q;
        resp_data  = resp_data_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a byte-lane memory model.
module tb_load_store_unit;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_wen;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        resp_err;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(8), .TAG_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_wen   (resp_wen),
        .resp_rd    (resp_rd),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    // Synchronous data memory: registered read, write on posedge.
    logic [31:0] mem [256];
    logic        init_mem;
    int unsigned wr_edges;
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
            mem_rdata <= 32'h0;
            wr_edges  <= 0;
        end else begin
            if (mem_write) begin
                mem[mem_addr[7:0]] <= mem_wdata;
                wr_edges <= wr_edges + 1;
            end
            if (mem_read) mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    // Reference memory image, updated from the architectural store rules.
    logic [31:0] ref_mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    int          t_lat, t_nrd, t_nwr, t_rdy;
    logic [31:0] t_data, t_wr_addr, t_wr_data;
    logic        t_wen, t_err;
    logic [4:0]  t_rd;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic is_store(logic [2:0] op);
        return op >= OP_SB;
    endfunction

    function automatic logic ref_mis(logic [2:0] op, logic [31:0] addr);
`ifdef LSU_MISALIGN_ERR_EN
        if (op == OP_LW || op == OP_SW) return (addr % 4) != 0;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return (addr % 2) != 0;
        return 1'b0;
`else
        return (op != op) || (addr != addr);
`endif
    endfunction

    function automatic int ref_idx(logic [31:0] addr);
        return int'((addr / 4) % 256);
    endfunction

    function automatic logic [31:0] ref_load(logic [2:0] op, logic [31:0] addr);
        logic [31:0] w, v;
        int off;
        w = ref_mem[ref_idx(addr)];
        v = w;
        if (op == OP_LB || op == OP_LBU) begin
            off = int'(addr % 4);
            v = (w >> (8 * off)) & 32'hFF;
            if (op == OP_LB && v >= 32'd128) v = v - 32'd256;
        end else if (op == OP_LH || op == OP_LHU) begin
            off = ((addr % 4) >= 2) ? 2 : 0;
            v = (w >> (8 * off)) & 32'hFFFF;
            if (op == OP_LH && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store_word(logic [2:0] op, logic [31:0] addr,
                                                   logic [31:0] wdata);
        logic [31:0] w, mask;
        int sh;
        w = ref_mem[ref_idx(addr)];
        if (op == OP_SB) begin
            sh = 8 * int'(addr % 4);
            mask = 32'hFF;
        end else if (op == OP_SH) begin
            sh = ((addr % 4) >= 2) ? 16 : 0;
            mask = 32'hFFFF;
        end else begin
            sh = 0;
            mask = 32'hFFFF_FFFF;
        end
        return (w & ~(mask << sh)) | ((wdata & mask) << sh);
    endfunction

    // Issue one request, then watch the DUT until its response pulse.
    task automatic run_req(input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd);
        int w;
        @(negedge clk);
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_wait: req_ready stuck low, required 1");
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_rd    = rd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_rd    = 5'($urandom);
        t_lat = 0; t_nrd = 0; t_nwr = 0; t_rdy = 0;
        t_data = 32'hDEAD_BEEF; t_wen = 1'bx; t_err = 1'bx; t_rd = 5'bx;
        t_wr_addr = 32'hx; t_wr_data = 32'hx;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_write) begin
                t_nwr++;
                t_wr_addr = mem_addr;
                t_wr_data = mem_wdata;
            end
            if (mem_read) t_nrd++;
            if (req_ready) t_rdy++;
            if (resp_valid) begin
                t_lat  = c;
                t_data = resp_data;
                t_wen  = resp_wen;
                t_err  = resp_err;
                t_rd   = resp_rd;
                break;
            end
        end
    endtask

    // Run a request and compare everything observable against the reference model.
    task automatic check_txn(input string name, input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [4:0] rd);
        logic        mis, st;
        int          exp_lat, exp_nrd, exp_nwr;
        logic [31:0] exp_data, exp_word;
        mis = ref_mis(op, addr);
        st  = is_store(op);
        exp_word = ref_store_word(op, addr, wdata);
        exp_data = (st || mis) ? 32'h0 : ref_load(op, addr);
        if (mis) begin
            exp_lat = 1; exp_nrd = 0; exp_nwr = 0;
        end else if (op == OP_SW) begin
            exp_lat = 2; exp_nrd = 0; exp_nwr = 1;
        end else if (st) begin
            exp_lat = 4; exp_nrd = 1; exp_nwr = 1;
        end else begin
            exp_lat = 3; exp_nrd = 1; exp_nwr = 0;
        end
        run_req(op, addr, wdata, rd);
        chk({name, " latency"}, 32'(t_lat), 32'(exp_lat));
        chk({name, " data"}, t_data, exp_data);
        chk({name, " wen"}, 32'(t_wen), 32'(!st && !mis));
        chk({name, " err"}, 32'(t_err), 32'(mis));
        chk({name, " rd"}, 32'(t_rd), 32'(rd));
        chk({name, " reads"}, 32'(t_nrd), 32'(exp_nrd));
        chk({name, " writes"}, 32'(t_nwr), 32'(exp_nwr));
        chk({name, " ready_low"}, 32'(t_rdy), 32'd0);
        if (exp_nwr == 1) begin
            chk({name, " wr_addr"}, t_wr_addr, 32'(ref_idx(addr)));
            chk({name, " wr_data"}, t_wr_data, exp_word);
        end
        if (st && !mis) ref_mem[ref_idx(addr)] = exp_word;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] exp_data;
        logic        exp_wen;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int first_resp, second_resp, acc2, early, saw_resp, saw_wr;
        int unsigned w0;
        logic [31:0] r, a;

        vecs[0] = '{OP_SW,  32'h20, 32'h808182F3, 5'd1,  32'h00000000, 1'b0, 2};
        vecs[1] = '{OP_LB,  32'h20, 32'h0,        5'd2,  32'hFFFFFFF3, 1'b1, 3};
        vecs[2] = '{OP_LBU, 32'h20, 32'h0,        5'd3,  32'h000000F3, 1'b1, 3};
        vecs[3] = '{OP_LH,  32'h22, 32'h0,        5'd4,  32'hFFFF8081, 1'b1, 3};
        vecs[4] = '{OP_LHU, 32'h22, 32'h0,        5'd5,  32'h00008081, 1'b1, 3};
        vecs[5] = '{OP_SB,  32'h21, 32'h00000055, 5'd6,  32'h00000000, 1'b0, 4};
        vecs[6] = '{OP_LW,  32'h20, 32'h0,        5'd7,  32'h808155F3, 1'b1, 3};
        vecs[7] = '{OP_SH,  32'h22, 32'h00001234, 5'd8,  32'h00000000, 1'b0, 4};
        vecs[8] = '{OP_LW,  32'h20, 32'h0,        5'd9,  32'h123455F3, 1'b1, 3};
        vecs[9] = '{OP_LW,  32'h14, 32'h0,        5'd31, 32'h00000005, 1'b1, 3};

        for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i);
        rst = 1'b1; init_mem = 1'b1;
        req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        init_mem = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset mem_read", 32'(mem_read), 32'd0);
        chk("reset mem_write", 32'(mem_write), 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        chk("reset resp_data", resp_data, 32'd0);
        chk("reset resp_wen", 32'(resp_wen), 32'd0);
        chk("reset resp_err", 32'(resp_err), 32'd0);
        chk("reset resp_rd", 32'(resp_rd), 32'd0);

        for (int i = 0; i < 10; i++) begin
            check_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata,
                      vecs[i].rd);
            chk($sformatf("vec%0d table_data", i), t_data, vecs[i].exp_data);
            chk($sformatf("vec%0d table_wen", i), 32'(t_wen), 32'(vecs[i].exp_wen));
            chk($sformatf("vec%0d table_lat", i), 32'(t_lat), 32'(vecs[i].exp_lat));
        end

        // Load result persists while idle.
        @(negedge clk);
        chk("hold resp_data", resp_data, 32'h5);
        chk("hold resp_valid", 32'(resp_valid), 32'd0);

`ifdef LSU_MISALIGN_ERR_EN
        check_txn("lw_mis", OP_LW, 32'h22, 32'h0, 5'd10);
        chk("lw_mis err_flag", 32'(t_err), 32'd1);
        chk("lw_mis lat1", 32'(t_lat), 32'd1);
`else
        check_txn("lw_unal", OP_LW, 32'h22, 32'h0, 5'd10);
        chk("lw_unal word8", t_data, 32'h123455F3);
`endif

        // Back-to-back: req_valid held high across the first request.
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h14; req_rd = 5'd3;
        @(posedge clk);
        #1;
        req_addr = 32'h10; req_rd = 5'd4;
        first_resp = 0; second_resp = 0; acc2 = 0; early = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (acc2 != 0 && c == acc2 + 1) req_valid = 1'b0;
            if (req_ready && first_resp == 0) early++;
            if (resp_valid) begin
                if (first_resp == 0) begin
                    first_resp = c;
                    chk("b2b first data", resp_data, 32'h5);
                    chk("b2b first rd", 32'(resp_rd), 32'd3);
                end else if (second_resp == 0) begin
                    second_resp = c;
                    chk("b2b second data", resp_data, 32'h4);
                    chk("b2b second rd", 32'(resp_rd), 32'd4);
                end
            end
            if (req_ready && first_resp != 0 && acc2 == 0) acc2 = c;
        end
        req_valid = 1'b0;
        chk("b2b first latency", 32'(first_resp), 32'd3);
        chk("b2b early ready", 32'(early), 32'd0);
        chk("b2b accept cycle", 32'(acc2), 32'd4);
        chk("b2b second latency", 32'(second_resp), 32'd7);

        // Reset during CAP of a sub-word store.
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_SB; req_addr = 32'h21; req_wdata = 32'hAA; req_rd = 5'd6;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        w0 = wr_edges;
        @(negedge clk);
        chk("abort rd strobe", 32'(mem_read), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort mem_write", 32'(mem_write), 32'd0);
        chk("abort mem_read", 32'(mem_read), 32'd0);
        chk("abort req_ready", 32'(req_ready), 32'd1);
        chk("abort mem_addr", mem_addr, 32'd0);
        chk("abort resp_data", resp_data, 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw_resp = 0; saw_wr = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (resp_valid) saw_resp++;
            if (mem_write) saw_wr++;
        end
        chk("abort no resp", 32'(saw_resp), 32'd0);
        chk("abort no write", 32'(saw_wr), 32'd0);
        chk("abort write edges", wr_edges, w0);
        chk("abort word8", mem[8], ref_mem[8]);
        chk("abort ready after", 32'(req_ready), 32'd1);

        // Randomized traffic over a small window, with wrapping high address bits.
        for (int k = 0; k < 80; k++) begin
            r = $urandom;
            a = (r & 32'hFFFF_FC00) | $urandom_range(0, 63);
            if (k % 10 == 0) a = a | 32'h3FC;
            check_txn($sformatf("rnd%0d", k), 3'($urandom_range(0, 7)), a, $urandom,
                      5'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage adapter between the EX stage (ALU result = byte address) and the word-addressed data memory (synchronous, 1-cycle registered read, write on posedge).
- Adds byte and halfword loads and stores: sign/zero extension on loads, read-modify-write for sub-word stores.
- Returns writeback data and a destination tag to the register file.
- Uses a valid/ready request handshake and a single-cycle response pulse.

Parameters:
- ADDR_W, 8, word-index width of data memory (256 words); byte address bits [ADDR_W+1:2] select the word, higher bits ignored (wrap).
- TAG_W, 5, destination register tag width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept (high only in IDLE)
- req_op  in  3  0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low byte/half used for SB/SH)
- req_rd  in  TAG_W  load destination register
- mem_addr  out  32  word index to memory, zero-extended from ADDR_W
- mem_wdata  out  32  full word to write
- mem_write  out  1  memory write strobe
- mem_read  out  1  memory read strobe
- mem_rdata  in  32  memory read data (valid the cycle after the mem_read edge)
- resp_valid  out  1  one-cycle completion pulse
- resp_wen  out  1  register write enable (loads only, no error)
- resp_rd  out  TAG_W  echoed tag
- resp_data  out  32  extended load data (0 for stores and errors)
- resp_err  out  1  misaligned access

Behaviour:
- Reset: state IDLE; every output 0 except req_ready=1; internal op/addr/data/tag registers cleared.
- Accept on a posedge with req_valid && req_ready (edge T0): op, addr, wdata and rd are latched. No accept outside IDLE. No response backpressure.
- FSM states: IDLE, RD, CAP, WR, RESP.
- mem_read=1 only in RD; mem_write=1 only in WR; mem_addr/mem_wdata are driven from latched registers in all non-IDLE states.
- LW/LH/LB/LHU/LBU: IDLE -> RD -> CAP -> RESP -> IDLE.
  - At the CAP->RESP edge the selected lane of mem_rdata is extracted, extended and registered into resp_data.
  - resp_valid is high in the third cycle after T0.
- SW: IDLE -> WR -> RESP -> IDLE.
  - mem_wdata = req_wdata; resp_valid is high in the second cycle after T0.
- SB/SH: IDLE -> RD -> CAP -> WR -> RESP -> IDLE.
  - In CAP, the new byte/half is merged into mem_rdata and registered as the write word.
  - All other bytes are unchanged; resp_valid is high in the fourth cycle after T0.
- Lanes are little-endian.
  - Byte k = bits [8k+7:8k], selected by addr[1:0].
  - Half = addr[1] ? [31:16] : [15:0].
- Extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
- RESP cycle outputs:
  - resp_valid=1; resp_rd = latched tag.
  - resp_wen=1 for loads; 0 for stores or error.
- resp_valid, resp_wen and resp_err are 0 in every other state. resp_data holds its value until the next RESP.
- Reserved/unknown op: none; all 8 encodings are defined.
- Reset mid-operation: immediately returns to IDLE and drops mem_write/mem_read asynchronously.
  - A sub-word RMW aborted before the WR edge leaves memory unchanged.
  - No response is produced for the aborted request.
- req_valid dropping after accept has no effect; the request completes.

Optional Feature:
- LSU_MISALIGN_ERR_EN defined:
  - Misaligned requests go IDLE -> RESP directly: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]=1.
  - No mem_read/mem_write is issued.
  - resp_err=1, resp_wen=0, resp_data=0; resp_valid is high in the first cycle after T0.
- Not defined:
  - Low address bits are forced aligned: word ops ignore addr[1:0]; halfword ops ignore addr[0].
  - Every request takes the normal path; resp_err is tied 0 (the port remains).

Decomposition:
- Package lsu_pkg:
  - op encodings LSU_LB..LSU_SW
  - state encoding IDLE/RD/CAP/WR/RESP
  - width constant WORD_W=32
- One combinational sub-module, lsu_lane_align:
  - Inputs: op, addr[1:0], word, store data.
  - Outputs: extended load data and merged store word.
  - Instantiated once; the FSM and registers stay in load_store_unit.

Test Plan:
- SW addr 0x20 data 0x808182F3 -> one mem_write with mem_addr=8, mem_wdata=0x808182F3; resp_valid 2 cycles after accept, resp_wen=0.
- After that store, from addr 0x20/0x22:
  - LB 0x20 -> 0xFFFFFFF3
  - LBU 0x20 -> 0x000000F3
  - LH 0x22 -> 0xFFFF8081
  - LHU 0x22 -> 0x00008081
  - Each with resp_wen=1, resp_rd echoed, latency 3.
- SB addr 0x21 data 0x00000055, then LW 0x20 -> 0x808155F3; SH addr 0x22 data 0x1234, then LW 0x20 -> 0x123455F3; SB latency 4, req_ready low throughout.
- LW addr 0x14 on a memory where word i holds i -> resp_data=5; back-to-back req_valid is held off until IDLE, and the second request is accepted the cycle after RESP.
- With LSU_MISALIGN_ERR_EN: LW 0x22 -> resp_err=1, resp_wen=0, no mem strobes, latency 1.
- Without LSU_MISALIGN_ERR_EN: LW 0x22 -> reads word 8.
- Assert rst during CAP of SB 0x21 -> mem_write never pulses, word 8 unchanged, no resp_valid, req_ready=1 after reset release.
